// File: rtl/id_entry_pkg.sv
// Shared types and constants for the numeric ID entry controller.
// Holds the session state enum, the blank-digit constant and the
// event-select encoding produced by the per-cycle priority resolver.
package id_entry_pkg;

  // Session states. WAIT_ACK is the only state in which id_valid is high.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_FULL     = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_e;

  // Nibble stored in a digit position that holds no digit.
  localparam logic [3:0] BLANK_DIGIT = 4'hA;

  // Largest value accepted as a decimal digit.
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // The single key event acted on in a cycle, after priority resolution.
  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_ESC   = 3'd1,
    EV_BKSP  = 3'd2,
    EV_ENTER = 3'd3,
    EV_DIGIT = 3'd4
  } event_e;

  // Priority resolver: esc > bksp > enter > digit. A digit pulse carrying
  // a value above 9 is not an event at all, so it never reaches the FSM.
  function automatic event_e resolve_event(
    input logic       esc,
    input logic       bksp,
    input logic       enter,
    input logic       digit,
    input logic [3:0] value
  );
    event_e ev;
    ev = EV_NONE;
    if (esc) begin
      ev = EV_ESC;
    end else if (bksp) begin
      ev = EV_BKSP;
    end else if (enter) begin
      ev = EV_ENTER;
    end else if (digit && (value <= MAX_DIGIT)) begin
      ev = EV_DIGIT;
    end
    return ev;
  endfunction

endpackage

// File: rtl/id_entry_timer.sv
// Inactivity counter for the ID entry controller.
// Counts while enabled, restarts on reload, and flags expire in the
// cycle the count sits at LIMIT-1 with no reload present. A reload in
// that same cycle wins, so an event arriving at the deadline keeps the
// session alive. Held at zero whenever enable is low.
module id_entry_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic CLK,
  input  logic reset,
  input  logic enable,
  input  logic reload,
  output logic expire
);

  localparam int unsigned CNTW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(LIMIT - 1);

  logic [CNTW-1:0] count_q;

  // Expiry is a combinational flag; the controller registers its effect.
  assign expire = enable && !reload && (count_q == LAST);

  // Count up while enabled; restart on reload, expiry or disable.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (!enable || reload || expire) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNTW'(1);
    end
  end

endmodule

// File: rtl/id_entry_ctrl.sv
// Session controller for numeric ID entry from decoded keyboard events.
// Assembles a NUM_DIGITS-long BCD ID, left-justified (digit 0 in the MSB
// nibble) and blank-filled, and presents it downstream once complete.
//
// Handshake: id_valid is high exactly while the session sits in WAIT_ACK.
// While id_valid is high, id_out is frozen and every key event is ignored.
// The consumer signals acceptance by raising id_ack in any cycle with
// id_valid high; on that edge the ID clears to blank and id_valid drops
// in the following cycle. id_ack while id_valid is low has no effect.
//
// Optional feature: define ID_ENTRY_TIMEOUT_EN to add an inactivity
// timer that clears an unfinished entry after TIMEOUT_CYCLES idle cycles
// and pulses timeout. Without it, timeout is tied low and an entry
// persists until esc, backspace-to-empty or the handshake completes.
module id_entry_ctrl
  import id_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 7,
  parameter logic [3:0]  BLANK          = BLANK_DIGIT,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic                            digit_evt,
  input  logic [3:0]                      digit_val,
  input  logic                            bksp_evt,
  input  logic                            enter_evt,
  input  logic                            esc_evt,
  input  logic                            id_ack,
  output logic [NUM_DIGITS*4-1:0]         id_out,
  output logic                            id_valid,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            busy,
  output logic                            err,
  output logic                            timeout,
  output state_e                          state_dbg
);

  localparam int unsigned IW = NUM_DIGITS * 4;
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam logic [IW-1:0] ALL_BLANK = {NUM_DIGITS{BLANK}};

  state_e          state_q;
  state_e          state_d;
  event_e          ev;
  logic            expire;

  // Actions decided by the FSM and carried out by the datapath.
  logic            do_write;
  logic            do_remove;
  logic            do_clear;
  logic            set_err;
  logic            set_timeout;

  logic [IW-1:0]   id_q;
  logic [IW-1:0]   id_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            err_q;
  logic            timeout_q;

  assign ev = resolve_event(esc_evt, bksp_evt, enter_evt, digit_evt, digit_val);

`ifdef ID_ENTRY_TIMEOUT_EN
  logic timer_enable;
  logic key_seen;

  // Both accepted and rejected key events count as activity.
  assign key_seen     = (ev != EV_NONE);
  assign timer_enable = (state_q == ST_ENTRY) || (state_q == ST_FULL);

  id_entry_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .reset  (reset),
    .enable (timer_enable),
    .reload (key_seen),
    .expire (expire)
  );
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath actions from the resolved event.
  always_comb begin
    state_d     = state_q;
    do_write    = 1'b0;
    do_remove   = 1'b0;
    do_clear    = 1'b0;
    set_err     = 1'b0;
    set_timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        case (ev)
          EV_DIGIT: begin
            do_write = 1'b1;
            state_d  = (NUM_DIGITS == 1) ? ST_FULL : ST_ENTRY;
          end
          EV_BKSP, EV_ENTER: set_err = 1'b1;
          default: ;
        endcase
      end
      ST_ENTRY: begin
        case (ev)
          EV_ESC: begin
            do_clear = 1'b1;
            state_d  = ST_IDLE;
          end
          EV_BKSP: begin
            do_remove = 1'b1;
            if (count_q == CW'(1)) begin
              state_d = ST_IDLE;
            end
          end
          EV_ENTER: set_err = 1'b1;
          EV_DIGIT: begin
            do_write = 1'b1;
            if (count_q == CW'(NUM_DIGITS - 1)) begin
              state_d = ST_FULL;
            end
          end
          default: begin
            if (expire) begin
              do_clear    = 1'b1;
              set_timeout = 1'b1;
              state_d     = ST_IDLE;
            end
          end
        endcase
      end
      ST_FULL: begin
        case (ev)
          EV_ESC: begin
            do_clear = 1'b1;
            state_d  = ST_IDLE;
          end
          EV_BKSP: begin
            do_remove = 1'b1;
            state_d   = (NUM_DIGITS == 1) ? ST_IDLE : ST_ENTRY;
          end
          EV_ENTER: state_d = ST_WAIT_ACK;
          EV_DIGIT: set_err = 1'b1;
          default: begin
            if (expire) begin
              do_clear    = 1'b1;
              set_timeout = 1'b1;
              state_d     = ST_IDLE;
            end
          end
        endcase
      end
      ST_WAIT_ACK: begin
        if (id_ack) begin
          do_clear = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    id_valid  = (state_q == ST_WAIT_ACK);
    state_dbg = state_q;
  end

  // Next ID contents and digit count for the chosen action.
  always_comb begin
    id_d    = id_q;
    count_d = count_q;
    if (do_clear) begin
      id_d    = ALL_BLANK;
      count_d = '0;
    end else if (do_write) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (count_q == CW'(i)) begin
          id_d[(NUM_DIGITS - i) * 4 - 1 -: 4] = digit_val;
        end
      end
      count_d = count_q + CW'(1);
    end else if (do_remove) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (count_q == CW'(i + 1)) begin
          id_d[(NUM_DIGITS - i) * 4 - 1 -: 4] = BLANK;
        end
      end
      count_d = count_q - CW'(1);
    end
  end

  // Datapath registers; err and timeout are single-cycle pulses.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      id_q      <= ALL_BLANK;
      count_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      id_q      <= id_d;
      count_q   <= count_d;
      err_q     <= set_err;
      timeout_q <= set_timeout;
    end
  end

  assign id_out      = id_q;
  assign digit_count = count_q;
  assign err         = err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_id_entry_ctrl.sv
// Directed bench for id_entry_ctrl: a vector table applied one event per
// cycle, followed by hand-written sequences for esc in FULL, asynchronous
// reset during the handshake and (when ID_ENTRY_TIMEOUT_EN is defined)
// the inactivity timeout with a 16-cycle limit.
module tb_id_entry_ctrl;
  import id_entry_pkg::*;

  logic        CLK;
  logic        reset;
  logic        digit_evt;
  logic [3:0]  digit_val;
  logic        bksp_evt;
  logic        enter_evt;
  logic        esc_evt;
  logic        id_ack;
  logic [27:0] id_out;
  logic        id_valid;
  logic [2:0]  digit_count;
  logic        busy;
  logic        err;
  logic        timeout;
  state_e      state_dbg;

  int n_cmp;
  int n_fail;

  typedef struct packed {
    logic        dig;
    logic [3:0]  val;
    logic        bk;
    logic        en;
    logic        es;
    logic        ack;
    logic [27:0] id;
    logic [2:0]  cnt;
    logic        vld;
    logic        bsy;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  id_entry_ctrl #(
    .NUM_DIGITS     (7),
    .BLANK          (4'hA),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .digit_evt   (digit_evt),
    .digit_val   (digit_val),
    .bksp_evt    (bksp_evt),
    .enter_evt   (enter_evt),
    .esc_evt     (esc_evt),
    .id_ack      (id_ack),
    .id_out      (id_out),
    .id_valid    (id_valid),
    .digit_count (digit_count),
    .busy        (busy),
    .err         (err),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  // Clock and reset.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  function automatic vec_t mk(
    input logic dig, input logic [3:0] val, input logic bk, input logic en,
    input logic es, input logic ack, input logic [27:0] id, input logic [2:0] cnt,
    input logic vld, input logic bsy, input logic er
  );
    vec_t v;
    v.dig = dig; v.val = val; v.bk = bk; v.en = en; v.es = es; v.ack = ack;
    v.id = id; v.cnt = cnt; v.vld = vld; v.bsy = bsy; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of events, then sample #1 after the capturing edge.
  task automatic drive(input logic dig, input logic [3:0] val, input logic bk,
                       input logic en, input logic es, input logic ack);
    @(negedge CLK);
    digit_evt = dig; digit_val = val; bksp_evt = bk;
    enter_evt = en;  esc_evt = es;    id_ack = ack;
    @(posedge CLK);
    #1;
    digit_evt = 1'b0; digit_val = 4'd0; bksp_evt = 1'b0;
    enter_evt = 1'b0; esc_evt = 1'b0;   id_ack = 1'b0;
  endtask

  task automatic key_digit(input logic [3:0] val);
    drive(1'b1, val, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    digit_evt = 1'b0; digit_val = 4'd0; bksp_evt = 1'b0;
    enter_evt = 1'b0; esc_evt = 1'b0;   id_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;

    //          dig val  bk   en   es   ack  id          cnt  vld  bsy  er
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 28'hAAAAAAA, 3'd0, 0, 0, 0));
    tbl.push_back(mk(1, 4'd2, 0, 0, 0, 0, 28'h2AAAAAA, 3'd1, 0, 1, 0));
    tbl.push_back(mk(1, 4'd0, 0, 0, 0, 0, 28'h20AAAAA, 3'd2, 0, 1, 0));
    tbl.push_back(mk(1, 4'd2, 0, 0, 0, 0, 28'h202AAAA, 3'd3, 0, 1, 0));
    tbl.push_back(mk(1, 4'd1, 0, 0, 0, 0, 28'h2021AAA, 3'd4, 0, 1, 0));
    tbl.push_back(mk(1, 4'd3, 0, 0, 0, 0, 28'h20213AA, 3'd5, 0, 1, 0));
    tbl.push_back(mk(1, 4'd4, 0, 0, 0, 0, 28'h202134A, 3'd6, 0, 1, 0));
    tbl.push_back(mk(1, 4'd5, 0, 0, 0, 0, 28'h2021345, 3'd7, 0, 1, 0));
    tbl.push_back(mk(1, 4'd8, 0, 0, 0, 0, 28'h2021345, 3'd7, 0, 1, 1));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 28'h2021345, 3'd7, 0, 1, 0));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 28'h2021345, 3'd7, 1, 1, 0));
    tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 28'h2021345, 3'd7, 1, 1, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 1, 0, 28'h2021345, 3'd7, 1, 1, 0));
    tbl.push_back(mk(0, 4'd0, 1, 1, 0, 0, 28'h2021345, 3'd7, 1, 1, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 28'h2021345, 3'd7, 1, 1, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 28'hAAAAAAA, 3'd0, 0, 0, 0));
    tbl.push_back(mk(1, 4'd1, 0, 0, 0, 0, 28'h1AAAAAA, 3'd1, 0, 1, 0));
    tbl.push_back(mk(1, 4'd2, 0, 0, 0, 0, 28'h12AAAAA, 3'd2, 0, 1, 0));
    tbl.push_back(mk(1, 4'd3, 0, 0, 0, 0, 28'h123AAAA, 3'd3, 0, 1, 0));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 28'h123AAAA, 3'd3, 0, 1, 1));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 28'h12AAAAA, 3'd2, 0, 1, 0));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 28'h1AAAAAA, 3'd1, 0, 1, 0));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 28'hAAAAAAA, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 28'hAAAAAAA, 3'd0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 28'hAAAAAAA, 3'd0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd0, 0, 0, 1, 0, 28'hAAAAAAA, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 28'hAAAAAAA, 3'd0, 0, 0, 0));
    tbl.push_back(mk(1, 4'd12, 0, 0, 0, 0, 28'hAAAAAAA, 3'd0, 0, 0, 0));
    tbl.push_back(mk(1, 4'd7, 0, 0, 0, 0, 28'h7AAAAAA, 3'd1, 0, 1, 0));
    tbl.push_back(mk(1, 4'd15, 0, 0, 0, 0, 28'h7AAAAAA, 3'd1, 0, 1, 0));
    tbl.push_back(mk(1, 4'd7, 0, 0, 1, 0, 28'hAAAAAAA, 3'd0, 0, 0, 0));
    tbl.push_back(mk(1, 4'd4, 0, 0, 0, 0, 28'h4AAAAAA, 3'd1, 0, 1, 0));
    tbl.push_back(mk(1, 4'd5, 1, 1, 0, 0, 28'hAAAAAAA, 3'd0, 0, 0, 0));
    tbl.push_back(mk(1, 4'd4, 0, 0, 0, 0, 28'h4AAAAAA, 3'd1, 0, 1, 0));
    tbl.push_back(mk(1, 4'd5, 0, 0, 0, 0, 28'h45AAAAA, 3'd2, 0, 1, 0));
    tbl.push_back(mk(1, 4'd6, 0, 1, 0, 0, 28'h45AAAAA, 3'd2, 0, 1, 1));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 28'h45AAAAA, 3'd2, 0, 1, 0));
    tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 28'h456AAAA, 3'd3, 0, 1, 0));
    tbl.push_back(mk(1, 4'd7, 0, 0, 0, 0, 28'h4567AAA, 3'd4, 0, 1, 0));
    tbl.push_back(mk(1, 4'd8, 0, 0, 0, 0, 28'h45678AA, 3'd5, 0, 1, 0));
    tbl.push_back(mk(1, 4'd9, 0, 0, 0, 0, 28'h456789A, 3'd6, 0, 1, 0));
    tbl.push_back(mk(1, 4'd0, 0, 0, 0, 0, 28'h4567890, 3'd7, 0, 1, 0));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 28'h456789A, 3'd6, 0, 1, 0));
    tbl.push_back(mk(1, 4'd1, 0, 0, 0, 0, 28'h4567891, 3'd7, 0, 1, 0));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 28'h4567891, 3'd7, 1, 1, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 28'hAAAAAAA, 3'd0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].dig, tbl[i].val, tbl[i].bk, tbl[i].en, tbl[i].es, tbl[i].ack);
      check($sformatf("v%0d_id", i),      32'(id_out),      32'(tbl[i].id));
      check($sformatf("v%0d_count", i),   32'(digit_count), 32'(tbl[i].cnt));
      check($sformatf("v%0d_valid", i),   32'(id_valid),    32'(tbl[i].vld));
      check($sformatf("v%0d_busy", i),    32'(busy),        32'(tbl[i].bsy));
      check($sformatf("v%0d_err", i),     32'(err),         32'(tbl[i].er));
      check($sformatf("v%0d_timeout", i), 32'(timeout),     32'(0));
    end

    // esc while FULL clears to IDLE.
    key_digit(4'd3); key_digit(4'd1); key_digit(4'd4); key_digit(4'd1);
    key_digit(4'd5); key_digit(4'd9);
    check("entry_state", 32'(state_dbg), 32'(ST_ENTRY));
    key_digit(4'd2);
    check("full_id", 32'(id_out), 32'h03141592);
    check("full_state", 32'(state_dbg), 32'(ST_FULL));
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_esc_id", 32'(id_out), 32'h0AAAAAAA);
    check("full_esc_busy", 32'(busy), 32'(0));

    // Asynchronous reset while id_valid is pending.
    key_digit(4'd9); key_digit(4'd8); key_digit(4'd7); key_digit(4'd6);
    key_digit(4'd5); key_digit(4'd4); key_digit(4'd3);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(id_valid), 32'(1));
    check("pre_rst_id", 32'(id_out), 32'h09876543);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check("async_rst_id", 32'(id_out), 32'h0AAAAAAA);
    check("async_rst_valid", 32'(id_valid), 32'(0));
    check("async_rst_count", 32'(digit_count), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    @(negedge CLK);
    reset = 1'b0;
    idle_cycle();
    check("post_rst_valid", 32'(id_valid), 32'(0));
    check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));

`ifdef ID_ENTRY_TIMEOUT_EN
    // Sixteen idle cycles after a digit expire the session.
    key_digit(4'd9);
    check("to_digit_id", 32'(id_out), 32'h09AAAAAA);
    for (int i = 1; i <= 15; i++) begin
      idle_cycle();
      check($sformatf("to_quiet%0d", i), 32'(timeout), 32'(0));
    end
    idle_cycle();
    check("to_pulse", 32'(timeout), 32'(1));
    check("to_clear_id", 32'(id_out), 32'h0AAAAAAA);
    check("to_clear_busy", 32'(busy), 32'(0));
    idle_cycle();
    check("to_pulse_width", 32'(timeout), 32'(0));

    // A digit in the expiry cycle wins and restarts the count.
    key_digit(4'd9);
    for (int i = 1; i <= 15; i++) begin
      idle_cycle();
    end
    key_digit(4'd3);
    check("to_reload_timeout", 32'(timeout), 32'(0));
    check("to_reload_id", 32'(id_out), 32'h093AAAAA);
    for (int i = 1; i <= 15; i++) begin
      idle_cycle();
      check($sformatf("to_reload_quiet%0d", i), 32'(timeout), 32'(0));
    end
    idle_cycle();
    check("to_reload_pulse", 32'(timeout), 32'(1));
    check("to_reload_clear", 32'(id_out), 32'h0AAAAAAA);
`else
    // Without the timer an entry persists through a long quiet period.
    key_digit(4'd9);
    for (int i = 0; i < 40; i++) begin
      idle_cycle();
    end
    check("no_to_timeout", 32'(timeout), 32'(0));
    check("no_to_id", 32'(id_out), 32'h09AAAAAA);
    check("no_to_busy", 32'(busy), 32'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
